// File: rtl/key_scan_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Holds the scan FSM state encoding, the row reset pattern and column decode.
// Pure declarations, no logic of its own.
package key_scan_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2
  } state_e;

  localparam logic [3:0] ROW_INIT = 4'b1110;
  localparam int         KEY_W    = 4;

  // Column decode result: vld is set only when exactly one column is low.
  typedef struct packed {
    logic       vld;
    logic [1:0] idx;
  } col_hit_t;

  function automatic col_hit_t one_low(input logic [3:0] col);
    col_hit_t h;
    h = '0;
    case (col)
      4'b1110: begin h.vld = 1'b1; h.idx = 2'd0; end
      4'b1101: begin h.vld = 1'b1; h.idx = 2'd1; end
      4'b1011: begin h.vld = 1'b1; h.idx = 2'd2; end
      4'b0111: begin h.vld = 1'b1; h.idx = 2'd3; end
      default: h = '0;
    endcase
    return h;
  endfunction

  // Active-low row drive for a row index: ROW_INIT rotated left by idx.
  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    logic [7:0] w;
    w = {ROW_INIT, ROW_INIT} << idx;
    return w[7:4];
  endfunction

endpackage

// File: rtl/key_matrix_scan_col_sync.sv
// 4-bit two-flop synchronizer for the keypad column lines.
// Latency: 2 clocks from i_col to o_col.
// No backpressure; resets to all-ones (idle, pulled-up columns).
module col_sync (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_col,
  output logic [3:0] o_col
);

  logic [3:0] r_meta;
  logic [3:0] r_sync;

  // Two-stage capture of the asynchronous column lines
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_col;
      r_sync <= r_meta;
    end
  end

  assign o_col = r_sync;

endmodule

// File: rtl/key_matrix_scan.sv
// 4x4 keypad scanner: row rotation, press/release debounce, key code output.
// Latency: press accepted DEB_CNT-1 clocks after debounce entry (plus 2-clock sync).
// No backpressure; o_key_valid is a one-cycle strobe, o_key_down a held level.
module key_matrix_scan
  import key_scan_pkg::*;
#(
  parameter int SCAN_DIV = 16,
  parameter int DEB_CNT  = 12
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [3:0]       i_col,
  output logic [3:0]       o_row,
  output logic [KEY_W-1:0] o_key_code,
  output logic             o_key_valid,
  output logic             o_key_down
);

  localparam int DW = $clog2(SCAN_DIV - 1) + 1;
  localparam int CW = $clog2(DEB_CNT) + 1;

  logic [3:0]       w_cols;
  col_hit_t         w_hit;
  state_e           r_state;
  state_e           w_state_nxt;
  logic [DW-1:0]    r_dwell;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_row_idx;
  logic [1:0]       r_col_idx;
  logic [3:0]       r_col_pat;
  logic [KEY_W-1:0] r_key_code;
  logic             r_key_valid;
  logic             r_key_down;
  logic             w_dwell_last;
  logic             w_cnt_full;
  logic             w_match;
  logic             w_idle;
  logic             w_accept;

  col_sync u_col_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_col   (i_col),
    .o_col   (w_cols)
  );

  assign w_hit        = one_low(w_cols);
  assign w_dwell_last = (r_dwell == DW'(SCAN_DIV - 1));
  // r_cnt already holds DEB_CNT-1 matches, so this cycle's sample is the last one needed
  assign w_cnt_full   = (r_cnt == CW'(DEB_CNT - 1));
  assign w_match      = (w_cols == r_col_pat);
  assign w_idle       = (w_cols == 4'hF);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= SCAN;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SCAN:     if (w_dwell_last && w_hit.vld) w_state_nxt = DEBOUNCE;
      DEBOUNCE: if (!w_match)                  w_state_nxt = SCAN;
                else if (w_cnt_full)           w_state_nxt = HOLD;
      HOLD:     if (w_idle && w_cnt_full)      w_state_nxt = SCAN;
      default:                                 w_state_nxt = SCAN;
    endcase
  end

  // Output decode: accept strobe and registered outputs onto ports
  always_comb begin
    w_accept    = (r_state == DEBOUNCE) && w_match && w_cnt_full;
    o_row       = row_drive(r_row_idx);
    o_key_code  = r_key_code;
    o_key_valid = r_key_valid;
    o_key_down  = r_key_down;
  end

  // Counters, row pointer, captured key and output registers.
  // Increments only happen below the terminal value, so counters never wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dwell     <= '0;
      r_cnt       <= '0;
      r_row_idx   <= '0;
      r_col_idx   <= '0;
      r_col_pat   <= '1;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
    end else begin
      r_key_valid <= w_accept;
      case (r_state)
        SCAN: begin
          if (w_dwell_last) begin
            r_dwell <= '0;
            if (w_hit.vld) begin
              r_col_pat <= w_cols;
              r_col_idx <= w_hit.idx;
              r_cnt     <= CW'(1);
            end else begin
              r_row_idx <= r_row_idx + 2'd1;
            end
          end else begin
            r_dwell <= r_dwell + DW'(1);
          end
        end
        DEBOUNCE: begin
          if (!w_match) begin
            r_cnt     <= '0;
            r_dwell   <= '0;
            r_row_idx <= r_row_idx + 2'd1;
          end else if (w_cnt_full) begin
            r_cnt      <= '0;
            r_key_code <= {r_row_idx, r_col_idx};
            r_key_down <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        HOLD: begin
          if (!w_idle) begin
            r_cnt <= '0;
          end else if (w_cnt_full) begin
            r_cnt      <= '0;
            r_key_down <= 1'b0;
            r_row_idx  <= '0;
            r_dwell    <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_dwell <= '0;
        end
      endcase
    end
  end

endmodule
